// File: rtl/serial_add_pkg.sv
// Shared types and constants for the serial add arbiter slice.
// Holds the FSM state encoding, the requester count and the counter sizing helper.
// No logic, so there is no latency or backpressure.
package serial_add_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        SHIFT = 2'b01,
        DONE  = 2'b10
    } state_t;

    localparam int REQ_N = 2;

    // The bit counter must hold values 0..WIDTH.
    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

endpackage

// File: rtl/serial_add_arbiter_if.sv
// Request/response bundle between two parallel-word clients and the serial adder.
// Wires only, so there is no latency.
// Requests use valid/ready per requester; the response uses a single valid/ready pair.
// Optional feature macro: SERIAL_ADD_SUB_EN adds the per-requester req_sub select.
interface serial_add_arbiter_if
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
);
    logic [REQ_N-1:0]       req_valid;
    logic [REQ_N-1:0]       req_ready;
    logic [REQ_N*WIDTH-1:0] req_a;
    logic [REQ_N*WIDTH-1:0] req_b;
`ifdef SERIAL_ADD_SUB_EN
    logic [REQ_N-1:0]       req_sub;
`endif
    logic                   rsp_valid;
    logic                   rsp_ready;
    logic                   rsp_id;
    logic [WIDTH-1:0]       rsp_sum;
    logic                   rsp_cout;

`ifdef SERIAL_ADD_SUB_EN
    modport master (
        output req_valid, req_a, req_b, req_sub, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
    modport slave (
        input  req_valid, req_a, req_b, req_sub, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
`else
    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_id, rsp_sum, rsp_cout
    );
`endif

endinterface

// File: rtl/serial_add_cell.sv
// One-bit full adder with a registered carry, shared by all serial operations.
// sum_bit is combinational from the current bits and the carry flop; the carry advances one edge per enabled bit.
// No backpressure: the sequencer decides when to load or advance the carry.
module serial_add_cell (
    input  logic clk,
    input  logic reset,
    input  logic a,
    input  logic b,
    input  logic load_cin,
    input  logic cin,
    input  logic en,
    output logic sum_bit,
    output logic cout
);

    logic carry_q;
    logic carry_d;

    // Full-adder sum, and the carry to store on the next edge (load has priority over advance).
    always_comb begin
        sum_bit = a ^ b ^ carry_q;
        carry_d = carry_q;
        if (load_cin) begin
            carry_d = cin;
        end else if (en) begin
            carry_d = (a & b) | (a & carry_q) | (b & carry_q);
        end
    end

    // Carry register, cleared asynchronously.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            carry_q <= 1'b0;
        end else begin
            carry_q <= carry_d;
        end
    end

    assign cout = carry_q;

endmodule

// File: rtl/serial_add_arbiter.sv
// Round-robin arbiter and sequencer feeding two requesters' operands LSB-first through one serial add cell.
// Accept at cycle T, rsp_valid high from cycle T+WIDTH+1; at most one op every WIDTH+2 cycles.
// req_ready is only offered in IDLE; the result is held in DONE until rsp_ready, no new accept meanwhile.
// Optional feature macro: SERIAL_ADD_SUB_EN enables subtraction (b inverted, carry-in 1).
module serial_add_arbiter
    import serial_add_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    serial_add_arbiter_if.slave  bus
);

    localparam int CW = cnt_width(WIDTH);

    state_t           state_q,  state_d;
    logic             rr_q,     rr_d;
    logic [CW-1:0]    cnt_q,    cnt_d;
    logic [WIDTH-1:0] a_sr_q,   a_sr_d;
    logic [WIDTH-1:0] b_sr_q,   b_sr_d;
    logic [WIDTH-1:0] sum_sr_q, sum_sr_d;
    logic             id_q,     id_d;
`ifdef SERIAL_ADD_SUB_EN
    logic             sub_q,    sub_d;
`endif

    logic             any_vld;
    logic             grant;
    logic             accept;
    logic             cin;
    logic             load_cin;
    logic             shift_en;
    logic             cell_b;
    logic             sum_bit;
    logic             carry;
    logic [WIDTH:0]   sum_cat;

    // Pick a requester: the only valid one, or the rr pointer on contention; offer ready only in IDLE.
    always_comb begin
        any_vld = |bus.req_valid;
        if (bus.req_valid == 2'b11) begin
            grant = rr_q;
        end else begin
            grant = bus.req_valid[1];
        end
        accept = (state_q == IDLE) && any_vld;
        if (accept) begin
            bus.req_ready = grant ? 2'b10 : 2'b01;
        end else begin
            bus.req_ready = 2'b00;
        end
`ifdef SERIAL_ADD_SUB_EN
        cin    = grant ? bus.req_sub[1] : bus.req_sub[0];
        cell_b = b_sr_q[0] ^ sub_q;
`else
        cin    = 1'b0;
        cell_b = b_sr_q[0];
`endif
    end

    serial_add_cell u_cell (
        .clk      (clk),
        .reset    (reset),
        .a        (a_sr_q[0]),
        .b        (cell_b),
        .load_cin (load_cin),
        .cin      (cin),
        .en       (shift_en),
        .sum_bit  (sum_bit),
        .cout     (carry)
    );

    // FSM next state: capture on accept, shift WIDTH bits, then hold the result until handshake.
    always_comb begin
        state_d  = state_q;
        rr_d     = rr_q;
        cnt_d    = cnt_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        sum_sr_d = sum_sr_q;
        id_d     = id_q;
`ifdef SERIAL_ADD_SUB_EN
        sub_d    = sub_q;
`endif
        load_cin = 1'b0;
        shift_en = 1'b0;
        sum_cat  = {sum_bit, sum_sr_q};
        case (state_q)
            IDLE: begin
                if (accept) begin
                    a_sr_d   = grant ? bus.req_a[2*WIDTH-1:WIDTH] : bus.req_a[WIDTH-1:0];
                    b_sr_d   = grant ? bus.req_b[2*WIDTH-1:WIDTH] : bus.req_b[WIDTH-1:0];
                    id_d     = grant;
`ifdef SERIAL_ADD_SUB_EN
                    sub_d    = cin;
`endif
                    cnt_d    = '0;
                    load_cin = 1'b1;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                shift_en = 1'b1;
                a_sr_d   = a_sr_q >> 1;
                b_sr_d   = b_sr_q >> 1;
                // New sum bit enters at the MSB, so after WIDTH bits the LSB sits at bit 0.
                sum_sr_d = sum_cat[WIDTH:1];
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    state_d = DONE;
                end
            end
            DONE: begin
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                    rr_d    = ~id_q;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Response outputs are driven only in DONE so nothing leaks while an op is in flight.
    always_comb begin
        bus.rsp_valid = (state_q == DONE);
        bus.rsp_id    = (state_q == DONE) ? id_q : 1'b0;
        bus.rsp_sum   = (state_q == DONE) ? sum_sr_q : '0;
        bus.rsp_cout  = (state_q == DONE) ? carry : 1'b0;
    end

    // State, pointer, counter and datapath registers; reset aborts any op in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            rr_q     <= 1'b0;
            cnt_q    <= '0;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            sum_sr_q <= '0;
            id_q     <= 1'b0;
`ifdef SERIAL_ADD_SUB_EN
            sub_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            rr_q     <= rr_d;
            cnt_q    <= cnt_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            sum_sr_q <= sum_sr_d;
            id_q     <= id_d;
`ifdef SERIAL_ADD_SUB_EN
            sub_q    <= sub_d;
`endif
        end
    end

endmodule
